// File: rtl/addr_seq_gen.sv
// Address sequence generator.
// Walks an address between latched inclusive bounds in one of four modes
// (up single-pass, down single-pass, up circular, ping-pong). It advances
// by a latched step on each enabled cycle in RUN.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start, abort, en  - load+run, return to IDLE, advance one step
//   mode              - 00 up, 01 down, 10 circular, 11 ping-pong
//   lo_bound/hi_bound - inclusive address bounds
//   step              - address increment (0 behaves as 1)
//   address, dir      - current address and direction (1 = up)
//   carry             - one-cycle pulse after a terminal step
//   busy, done        - state is RUN / DONE
//   cfg_err           - one-cycle pulse when a start is rejected (lo > hi)
module addr_seq_gen #(
  parameter int unsigned AD_W = 4,
  parameter int unsigned ST_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [AD_W-1:0] lo_bound,
  input  logic [AD_W-1:0] hi_bound,
  input  logic [ST_W-1:0] step,
  output logic [AD_W-1:0] address,
  output logic            carry,
  output logic            dir,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  localparam int unsigned XW = AD_W + 1;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_CIRC = 2'b10;
  localparam logic [1:0] MODE_PING = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  logic [1:0]      cfg_mode;
  logic [AD_W-1:0] cfg_lo;
  logic [AD_W-1:0] cfg_hi;
  logic [ST_W-1:0] cfg_step;

  logic            start_ok_c;
  logic [ST_W-1:0] eff_step_c;
  logic [XW-1:0]   span_c;
  logic            term_c;
  logic [AD_W-1:0] addr_next_c;

  // Start qualification and effective step for the incoming configuration.
  always_comb begin
    start_ok_c = (lo_bound <= hi_bound);
    eff_step_c = (step == '0) ? ST_W'(1) : step;
  end

  // Distance to the bound in the current direction, one bit wider so it
  // never wraps; a step larger than that distance is terminal.
  always_comb begin
    span_c      = '0;
    addr_next_c = address;
    if (dir) begin
      span_c      = XW'(cfg_hi) - XW'(address);
      addr_next_c = address + AD_W'(cfg_step);
    end else begin
      span_c      = XW'(address) - XW'(cfg_lo);
      addr_next_c = address - AD_W'(cfg_step);
    end
    term_c = (span_c < XW'(cfg_step));
  end

  // Sequencer state, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      address  <= '0;
      dir      <= 1'b1;
      carry    <= 1'b0;
      cfg_err  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_mode <= MODE_UP;
      cfg_lo   <= '0;
      cfg_hi   <= '0;
      cfg_step <= ST_W'(1);
    end else begin
      carry   <= 1'b0;
      cfg_err <= 1'b0;
      if (start) begin
        if (start_ok_c) begin
          cfg_mode <= mode;
          cfg_lo   <= lo_bound;
          cfg_hi   <= hi_bound;
          cfg_step <= eff_step_c;
          state    <= RUN;
          busy     <= 1'b1;
          done     <= 1'b0;
          if (mode == MODE_DOWN) begin
            address <= hi_bound;
            dir     <= 1'b0;
          end else begin
            address <= lo_bound;
            dir     <= 1'b1;
          end
        end else begin
          // Rejected start freezes everything else this cycle.
          cfg_err <= 1'b1;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (state == RUN && en) begin
        if (!term_c) begin
          address <= addr_next_c;
        end else begin
          carry <= 1'b1;
          case (cfg_mode)
            MODE_CIRC: address <= cfg_lo;
            MODE_PING: dir <= ~dir;
            default: begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_addr_seq_gen.sv
// Directed, table-driven bench for addr_seq_gen (AD_W=4, ST_W=3).
// Each table row is one clock: inputs driven before the edge, outputs
// checked 1 time unit after it.
module tb_addr_seq_gen;

  logic       clk = 1'b0;
  logic       reset, start, abort, en;
  logic [1:0] mode;
  logic [3:0] lo_bound, hi_bound;
  logic [2:0] step;
  logic [3:0] address;
  logic       carry, dir, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addr_seq_gen #(.AD_W(4), .ST_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .en       (en),
    .mode     (mode),
    .lo_bound (lo_bound),
    .hi_bound (hi_bound),
    .step     (step),
    .address  (address),
    .carry    (carry),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  typedef struct {
    logic       rst, st, ab, en;
    logic [1:0] md;
    logic [3:0] lo, hi;
    logic [2:0] stp;
    logic [3:0] e_addr;
    logic       e_carry, e_dir, e_busy, e_done, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic ab,
                              input logic e, input logic [1:0] md,
                              input logic [3:0] lo, input logic [3:0] hi,
                              input logic [2:0] stp, input logic [3:0] ea,
                              input logic ec, input logic ed, input logic eb,
                              input logic edn, input logic ee);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.en = e; v.md = md;
    v.lo = lo; v.hi = hi; v.stp = stp;
    v.e_addr = ea; v.e_carry = ec; v.e_dir = ed;
    v.e_busy = eb; v.e_done = edn; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic ab, input logic e,
                       input logic [1:0] md, input logic [3:0] lo, input logic [3:0] hi,
                       input logic [2:0] stp);
    @(negedge clk);
    reset = rst; start = st; abort = ab; en = e;
    mode = md; lo_bound = lo; hi_bound = hi; step = stp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] ea, input logic ec,
                           input logic ed, input logic eb, input logic edn, input logic ee);
    check({tag, ".address"}, 16'(address), 16'(ea));
    check({tag, ".carry"},   16'(carry),   16'(ec));
    check({tag, ".dir"},     16'(dir),     16'(ed));
    check({tag, ".busy"},    16'(busy),    16'(eb));
    check({tag, ".done"},    16'(done),    16'(edn));
    check({tag, ".cfg_err"}, 16'(cfg_err), 16'(ee));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; en = 1'b0;
    mode = 2'b00; lo_bound = '0; hi_bound = '0; step = '0;

    //                rst st ab en md     lo  hi  stp  addr c  d  b  dn err
    // Reset state
    vecs.push_back(mk(1, 0, 0, 0, 2'd0,  0,  0, 0,   0, 0, 1, 0, 0, 0));
    // Up single-pass lo=2 hi=9 step=3; inputs change after start (latched)
    vecs.push_back(mk(0, 1, 0, 0, 2'd0,  2,  9, 3,   2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 1,   5, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 1,   8, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 1,   8, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 1,   8, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1,  0, 15, 1,   8, 0, 1, 0, 1, 0));
    // Down single-pass lo=0 hi=15 step=4, started from DONE
    vecs.push_back(mk(0, 1, 0, 0, 2'd1,  0, 15, 4,  15, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 4,  11, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 4,   7, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 4,   3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd1,  0, 15, 4,   3, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'd1,  0, 15, 4,   3, 0, 0, 0, 1, 0));
    // Ping-pong lo=3 hi=5 step=1, with an en=0 hold in the middle
    vecs.push_back(mk(0, 1, 0, 0, 2'd3,  3,  5, 1,   3, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   4, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   5, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   5, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   4, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'd3,  3,  5, 1,   4, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   3, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   4, 0, 1, 1, 0, 0));
    // Abort to IDLE holds address; en ignored in IDLE
    vecs.push_back(mk(0, 0, 1, 1, 2'd3,  3,  5, 1,   4, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  3,  5, 1,   4, 0, 1, 0, 0, 0));
    // Rejected start lo=9 hi=2: cfg_err one cycle, stays IDLE
    vecs.push_back(mk(0, 1, 0, 0, 2'd0,  9,  2, 1,   4, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2'd0,  9,  2, 1,   4, 0, 1, 0, 0, 0));
    // Start beats abort; step=0 behaves as 1; run to 7 then reset over start+en
    vecs.push_back(mk(0, 1, 1, 0, 2'd0,  0, 15, 0,   0, 0, 1, 1, 0, 0));
    for (int a = 1; a <= 7; a++)
      vecs.push_back(mk(0, 0, 0, 1, 2'd0, 0, 15, 0, 4'(a), 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 2'd0,  0, 15, 0,   0, 0, 1, 0, 0, 0));
    // Ping-pong lo==hi: every en terminal, carry back-to-back, dir toggles
    vecs.push_back(mk(0, 1, 0, 0, 2'd3,  6,  6, 2,   6, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  6,  6, 2,   6, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  6,  6, 2,   6, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2'd3,  6,  6, 2,   6, 1, 0, 1, 0, 0));
    // Rejected start during RUN leaves the run untouched
    vecs.push_back(mk(0, 1, 0, 1, 2'd0,  5,  4, 1,   6, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 2'd0,  5,  4, 1,   6, 1, 1, 1, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].ab, vecs[i].en,
            vecs[i].md, vecs[i].lo, vecs[i].hi, vecs[i].stp);
      check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_carry,
                vecs[i].e_dir, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
    end

    // Circular lo=0 hi=15 step=1: 17 steps wrap 15 -> 0, carry only after 15
    drive(0, 1, 0, 0, 2'd2, 0, 15, 1);
    check_all("circ.start", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      drive(0, 0, 0, 1, 2'd0, 4, 4, 7);
      check_all($sformatf("circ%0d", i), 4'(i % 16), 1'(i == 16), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Up single-pass with large step: 0,7,14 then terminal (15-14 < 7)
    drive(0, 1, 0, 0, 2'd0, 0, 15, 7);
    check_all("big.start", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 2'd0, 0, 15, 7);
    check_all("big.s1", 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 2'd0, 0, 15, 7);
    check_all("big.s2", 4'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 2'd0, 0, 15, 7);
    check_all("big.term", 4'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
